icache: RTL and testbench

//  Direct-mapped, read-only instruction cache between the IF stage and the memory simulator's

---
 rtl/icache_pkg.sv | 19 +
 rtl/icache_store.sv | 50 +++++
 rtl/icache.sv | 126 ++++++++++++
 tb/tb_icache.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared encodings and types for the direct-mapped instruction cache.
// The optional statistics counters are enabled with the ICACHE_STAT_EN macro.
package icache_pkg;

    localparam int IC_NUM_LINES = 64;

    localparam logic [1:0] IC_ST_IDLE = 2'd0;
    localparam logic [1:0] IC_ST_MISS = 2'd1;
    localparam logic [1:0] IC_ST_WAIT = 2'd2;

    typedef logic [63:0] ic_line_t;
    typedef logic [31:0] inst_t;

    // Pick the 32-bit instruction out of a 64-bit line using byte-address bit 2.
    function automatic inst_t ic_sel_word(input ic_line_t line, input logic hi);
        return hi ? line[63:32] : line[31:0];
    endfunction

endpackage

// File: rtl/icache_store.sv
// Valid/tag/data arrays for the instruction cache: one combinational read port,
// one write port, synchronous flush and asynchronous reset of the valid bits only.
module icache_store
    import icache_pkg::*;
#(
    parameter int NUM_LINES = IC_NUM_LINES,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = 29 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output ic_line_t         rd_line_o,
    input  logic             wr_en_i,
    input  logic             wr_valid_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  ic_line_t         wr_line_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    ic_line_t             line_q [NUM_LINES];

    // Flush has priority over a refill landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            line_q[wr_idx_i] <= wr_line_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_line_o  = line_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: hit compare, miss FSM and refill control.
// Define ICACHE_STAT_EN to add the stat_hit_o / stat_miss_o counters.
module icache
    import icache_pkg::*;
#(
    parameter int NUM_LINES = IC_NUM_LINES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        flush_i,
    output logic [31:0] ic_inst_o,
    output logic        ic_valid_o,
    output logic        ic_stall_o,
    output logic        ms_req_o,
    output logic [31:0] ms_addr_o,
    input  logic        ms_rep_i,
    input  logic [63:0] ms_rep_data_i
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] stat_hit_o,
    output logic [31:0] stat_miss_o
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 29 - IDX_W;

    logic [1:0]       state_q, state_d;
    logic [31:0]      miss_addr_q, miss_addr_d;
    logic             flush_pend_q, flush_pend_d;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    ic_line_t         rd_line;
    logic             idle, hit, start_miss, refill;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^if_addr_i[1:0];

    icache_store #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .rd_idx_i   (if_addr_i[3 +: IDX_W]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_line_o  (rd_line),
        .wr_en_i    (refill),
        .wr_valid_i (~flush_pend_q),
        .wr_idx_i   (miss_addr_q[3 +: IDX_W]),
        .wr_tag_i   (miss_addr_q[31:3+IDX_W]),
        .wr_line_i  (ms_rep_data_i)
    );

    assign idle       = (state_q == IC_ST_IDLE);
    assign hit        = idle & if_req_i & rd_valid & (rd_tag == if_addr_i[31:3+IDX_W]);
    assign start_miss = idle & if_req_i & ~hit & ~flush_i;
    assign refill     = (state_q == IC_ST_WAIT) & ms_rep_i;

    // A flush seen while a miss is outstanding may have made the fetched line
    // stale, so the refill is still accepted but its valid bit stays clear.
    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            IC_ST_IDLE: begin
                flush_pend_d = 1'b0;
                if (start_miss) begin
                    state_d     = IC_ST_MISS;
                    miss_addr_d = {if_addr_i[31:3], 3'b000};
                end
            end
            IC_ST_MISS: begin
                state_d = IC_ST_WAIT;
                if (flush_i) flush_pend_d = 1'b1;
            end
            IC_ST_WAIT: begin
                if (flush_i) flush_pend_d = 1'b1;
                if (ms_rep_i) state_d = IC_ST_IDLE;
            end
            default: state_d = IC_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IC_ST_IDLE;
            miss_addr_q  <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign ic_valid_o = hit;
    assign ic_inst_o  = hit ? ic_sel_word(rd_line, if_addr_i[2]) : 32'h0;
    assign ic_stall_o = (if_req_i & ~hit) | ~idle;
    assign ms_req_o   = (state_q == IC_ST_MISS);
    assign ms_addr_o  = miss_addr_q;

`ifdef ICACHE_STAT_EN
    logic [31:0] stat_hit_q, stat_miss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hit_q  <= '0;
            stat_miss_q <= '0;
        end else begin
            if (hit)        stat_hit_q  <= stat_hit_q + 32'd1;
            if (start_miss) stat_miss_q <= stat_miss_q + 32'd1;
        end
    end

    assign stat_hit_o  = stat_hit_q;
    assign stat_miss_o = stat_miss_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus a randomized run
// against a line-residency model and a fixed memory image.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst, if_req_i, flush_i, ms_rep_i;
    logic [31:0] if_addr_i;
    logic [63:0] ms_rep_data_i;
    logic [31:0] ic_inst_o, ms_addr_o;
    logic        ic_valid_o, ic_stall_o, ms_req_o;
`ifdef ICACHE_STAT_EN
    logic [31:0] stat_hit_o, stat_miss_o;
`endif

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    bit          ref_v  [64];
    logic [28:0] ref_la [64];

    always #5 clk = ~clk;

    icache dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .flush_i       (flush_i),
        .ic_inst_o     (ic_inst_o),
        .ic_valid_o    (ic_valid_o),
        .ic_stall_o    (ic_stall_o),
        .ms_req_o      (ms_req_o),
        .ms_addr_o     (ms_addr_o),
        .ms_rep_i      (ms_rep_i),
        .ms_rep_data_i (ms_rep_data_i)
`ifdef ICACHE_STAT_EN
        ,
        .stat_hit_o    (stat_hit_o),
        .stat_miss_o   (stat_miss_o)
`endif
    );

    // Memory image: line 0 holds {0xBBBB, 0xAAAA}, everything else is a hash of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a[31:3] == 29'd0) return a[2] ? 32'h0000_BBBB : 32'h0000_AAAA;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h5EED_C0DE;
    endfunction

    function automatic logic [63:0] mem_line(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:3], 3'b000};
        return {mem_word(b + 32'd4), mem_word(b)};
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return ref_v[a[8:3]] && (ref_la[a[8:3]] == a[31:3]);
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        ref_v[a[8:3]]  = 1'b1;
        ref_la[a[8:3]] = a[31:3];
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < 64; i++) ref_v[i] = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the memory reply for the line holding a after d idle WAIT cycles.
    task automatic serve(input logic [31:0] a, input int d, input bit fl);
        repeat (d) tick();
        ms_rep_i      = 1'b1;
        ms_rep_data_i = mem_line(a);
        flush_i       = fl;
        tick();
        ms_rep_i      = 1'b0;
        ms_rep_data_i = '0;
        flush_i       = 1'b0;
        if (fl) model_flush();
        else    model_fill(a);
    endtask

    task automatic do_reset();
        rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0; flush_i = 1'b0;
        ms_rep_i = 1'b0; ms_rep_data_i = '0;
        tick(); tick();
        rst = 1'b0;
        model_flush();
        exp_hits = 0; exp_misses = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0; flush_i = 1'b0;
        ms_rep_i = 1'b0; ms_rep_data_i = '0;
        @(negedge clk);
        checks++; if (ic_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ic_valid_o); end
        checks++; if (ic_inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", ic_inst_o); end
        checks++; if (ms_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", ms_req_o); end
        checks++; if (ms_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", ms_addr_o); end
        checks++; if (ic_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", ic_stall_o); end
`ifdef ICACHE_STAT_EN
        checks++; if (stat_hit_o !== 32'd0 || stat_miss_o !== 32'd0) begin
            errors++; $display("FAIL reset_stats got %0d/%0d exp 0/0", stat_hit_o, stat_miss_o); end
`endif
        tick();
        rst = 1'b0;
        model_flush();
    endtask

    task automatic test_cold_miss();
        if_req_i = 1'b1; if_addr_i = 32'h4;
        @(negedge clk);
        checks++; if (ic_valid_o !== 1'b0 || ic_stall_o !== 1'b1) begin
            errors++; $display("FAIL cold_t got valid %b stall %b exp 0 1", ic_valid_o, ic_stall_o); end
        tick();
        @(negedge clk);
        checks++; if (ms_req_o !== 1'b1 || ms_addr_o !== 32'h0) begin
            errors++; $display("FAIL cold_t1_req got %b addr %h exp 1 0", ms_req_o, ms_addr_o); end
        tick();
        ms_rep_i = 1'b1; ms_rep_data_i = mem_line(32'h0);
        @(negedge clk);
        checks++; if (ms_req_o !== 1'b0 || ic_stall_o !== 1'b1) begin
            errors++; $display("FAIL cold_t2 got req %b stall %b exp 0 1", ms_req_o, ic_stall_o); end
        tick();
        ms_rep_i = 1'b0; ms_rep_data_i = '0;
        model_fill(32'h0);
        @(negedge clk);
        checks++; if (ic_valid_o !== 1'b1 || ic_inst_o !== 32'h0000_BBBB || ic_stall_o !== 1'b0) begin
            errors++; $display("FAIL cold_t3_hit got valid %b inst %h stall %b exp 1 0000bbbb 0", ic_valid_o, ic_inst_o, ic_stall_o); end
        tick();
    endtask

    task automatic test_spatial_hit();
        if_addr_i = 32'h0;
        @(negedge clk);
        checks++; if (ic_valid_o !== 1'b1 || ic_inst_o !== 32'h0000_AAAA) begin
            errors++; $display("FAIL spatial_hit got valid %b inst %h exp 1 0000aaaa", ic_valid_o, ic_inst_o); end
        checks++; if (ms_req_o !== 1'b0 || ic_stall_o !== 1'b0) begin
            errors++; $display("FAIL spatial_req got req %b stall %b exp 0 0", ms_req_o, ic_stall_o); end
        tick();
        if_req_i = 1'b0;
    endtask

    task automatic test_conflict();
        if_req_i = 1'b1; if_addr_i = 32'h000;
        @(negedge clk);
        checks++; if (ic_valid_o !== 1'b1) begin errors++; $display("FAIL conflict_pre_hit got %b exp 1", ic_valid_o); end
        tick();
        if_addr_i = 32'h200;
        @(negedge clk);
        checks++; if (ic_valid_o !== 1'b0) begin errors++; $display("FAIL conflict_miss1 got %b exp 0", ic_valid_o); end
        tick();
        @(negedge clk);
        checks++; if (ms_req_o !== 1'b1 || ms_addr_o !== 32'h200) begin
            errors++; $display("FAIL conflict_req1 got %b addr %h exp 1 00000200", ms_req_o, ms_addr_o); end
        tick();
        serve(32'h200, 0, 1'b0);
        if_addr_i = 32'h000;
        @(negedge clk);
        checks++; if (ic_valid_o !== 1'b0) begin errors++; $display("FAIL conflict_miss2 got %b exp 0", ic_valid_o); end
        tick();
        @(negedge clk);
        checks++; if (ms_req_o !== 1'b1 || ms_addr_o !== 32'h000) begin
            errors++; $display("FAIL conflict_req2 got %b addr %h exp 1 00000000", ms_req_o, ms_addr_o); end
        tick();
        if_req_i = 1'b0;
        serve(32'h000, 1, 1'b0);
    endtask

    task automatic test_stats();
`ifdef ICACHE_STAT_EN
        @(negedge clk);
        checks++; if (stat_hit_o !== 32'd3 || stat_miss_o !== 32'd3) begin
            errors++; $display("FAIL stats_3 got %0d/%0d exp 3/3", stat_hit_o, stat_miss_o); end
        tick();
`endif
    endtask

    task automatic test_flush();
        // Hit reported in the flush cycle, then the flushed line misses.
        if_req_i = 1'b1; if_addr_i = 32'h4; flush_i = 1'b1;
        @(negedge clk);
        checks++; if (ic_valid_o !== 1'b1 || ic_inst_o !== 32'h0000_BBBB) begin
            errors++; $display("FAIL flush_cycle_hit got %b %h exp 1 0000bbbb", ic_valid_o, ic_inst_o); end
        tick();
        flush_i = 1'b0;
        model_flush();
        @(negedge clk);
        checks++; if (ic_valid_o !== 1'b0) begin errors++; $display("FAIL flush_after got %b exp 0", ic_valid_o); end
        tick();
        @(negedge clk);
        checks++; if (ms_req_o !== 1'b1) begin errors++; $display("FAIL flush_req got %b exp 1", ms_req_o); end
        tick();
        serve(32'h4, 0, 1'b1);
        @(negedge clk);
        checks++; if (ic_valid_o !== 1'b0 || ic_stall_o !== 1'b1) begin
            errors++; $display("FAIL flush_wait_inval got valid %b stall %b exp 0 1", ic_valid_o, ic_stall_o); end
        tick();
        @(negedge clk);
        checks++; if (ms_req_o !== 1'b1 || ms_addr_o !== 32'h0) begin
            errors++; $display("FAIL flush_refetch_req got %b addr %h exp 1 0", ms_req_o, ms_addr_o); end
        tick();
        serve(32'h4, 0, 1'b0);
        @(negedge clk);
        checks++; if (ic_valid_o !== 1'b1 || ic_inst_o !== 32'h0000_BBBB) begin
            errors++; $display("FAIL flush_refill_hit got %b %h exp 1 0000bbbb", ic_valid_o, ic_inst_o); end
        tick();
        // Flush in IDLE suppresses the miss that would otherwise start.
        if_addr_i = 32'h408; flush_i = 1'b1;
        @(negedge clk);
        checks++; if (ic_valid_o !== 1'b0) begin errors++; $display("FAIL flush_idle_valid got %b exp 0", ic_valid_o); end
        tick();
        flush_i = 1'b0; if_req_i = 1'b0;
        model_flush();
        @(negedge clk);
        checks++; if (ms_req_o !== 1'b0) begin errors++; $display("FAIL flush_idle_noreq got %b exp 0", ms_req_o); end
`ifdef ICACHE_STAT_EN
        checks++; if (stat_hit_o !== 32'd5 || stat_miss_o !== 32'd5) begin
            errors++; $display("FAIL flush_stats got %0d/%0d exp 5/5", stat_hit_o, stat_miss_o); end
`endif
        tick();
    endtask

    task automatic test_reset_mid_miss();
        if_req_i = 1'b1; if_addr_i = 32'h10;
        @(negedge clk);
        checks++; if (ic_valid_o !== 1'b0) begin errors++; $display("FAIL rmm_miss got %b exp 0", ic_valid_o); end
        tick();
        tick();
        if_req_i = 1'b0; rst = 1'b1;
        #1;
        checks++; if (ms_req_o !== 1'b0 || ms_addr_o !== 32'h0 || ic_stall_o !== 1'b0) begin
            errors++; $display("FAIL rmm_async got req %b addr %h stall %b exp 0 0 0", ms_req_o, ms_addr_o, ic_stall_o); end
        tick();
        rst = 1'b0;
        model_flush();
        ms_rep_i = 1'b1; ms_rep_data_i = ~mem_line(32'h10);
        tick();
        ms_rep_i = 1'b0; ms_rep_data_i = '0;
        if_req_i = 1'b1;
        @(negedge clk);
        checks++; if (ic_valid_o !== 1'b0 || ic_stall_o !== 1'b1) begin
            errors++; $display("FAIL rmm_late_ignored got valid %b stall %b exp 0 1", ic_valid_o, ic_stall_o); end
        tick();
        @(negedge clk);
        checks++; if (ms_req_o !== 1'b1 || ms_addr_o !== 32'h10) begin
            errors++; $display("FAIL rmm_req got %b addr %h exp 1 00000010", ms_req_o, ms_addr_o); end
        tick();
        @(negedge clk);
        checks++; if (ms_req_o !== 1'b0) begin errors++; $display("FAIL rmm_req_one_cycle got %b exp 0", ms_req_o); end
        serve(32'h10, 0, 1'b0);
        @(negedge clk);
        checks++; if (ic_valid_o !== 1'b1 || ic_inst_o !== mem_word(32'h10)) begin
            errors++; $display("FAIL rmm_hit got %b %h exp 1 %h", ic_valid_o, ic_inst_o, mem_word(32'h10)); end
        tick();
        if_req_i = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit          e;
        int          kind, d;
        do_reset();
        for (int it = 0; it < 400; it++) begin
            a = (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 3)) << 3) | 32'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = $urandom;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                if_req_i = 1'b0; ms_rep_i = 1'b1; ms_rep_data_i = {$urandom, $urandom};
                tick();
                ms_rep_i = 1'b0; ms_rep_data_i = '0;
            end else begin
                if_req_i = 1'b1; if_addr_i = a; flush_i = (kind == 1);
                e = model_hit(a);
                @(negedge clk);
                checks++; if (ic_valid_o !== e) begin
                    errors++; $display("FAIL rnd_valid addr %h got %b exp %b", a, ic_valid_o, e); end
                if (e) begin
                    exp_hits++;
                    checks++; if (ic_inst_o !== mem_word(a)) begin
                        errors++; $display("FAIL rnd_inst addr %h got %h exp %h", a, ic_inst_o, mem_word(a)); end
                end
                tick();
                if (kind == 1) begin
                    flush_i = 1'b0; if_req_i = 1'b0;
                    model_flush();
                    @(negedge clk);
                    checks++; if (ms_req_o !== 1'b0) begin errors++; $display("FAIL rnd_flush_noreq got %b exp 0", ms_req_o); end
                    tick();
                end else if (!e) begin
                    exp_misses++;
                    @(negedge clk);
                    checks++; if (ms_req_o !== 1'b1 || ms_addr_o !== {a[31:3], 3'b000}) begin
                        errors++; $display("FAIL rnd_req got %b addr %h exp 1 %h", ms_req_o, ms_addr_o, {a[31:3], 3'b000}); end
                    tick();
                    d = $urandom_range(0, 3);
                    for (int k = 0; k < d; k++) begin
                        if_addr_i = $urandom;
                        @(negedge clk);
                        checks++; if (ic_valid_o !== 1'b0 || ms_req_o !== 1'b0) begin
                            errors++; $display("FAIL rnd_wait got valid %b req %b exp 0 0", ic_valid_o, ms_req_o); end
                        tick();
                    end
                    serve(a, 0, 1'b0);
                end
            end
        end
        if_req_i = 1'b0;
`ifdef ICACHE_STAT_EN
        @(negedge clk);
        checks++; if (stat_hit_o !== 32'(exp_hits) || stat_miss_o !== 32'(exp_misses)) begin
            errors++; $display("FAIL rnd_stats got %0d/%0d exp %0d/%0d", stat_hit_o, stat_miss_o, exp_hits, exp_misses); end
        tick();
`endif
        $display("random run: %0d hits %0d misses", exp_hits, exp_misses);
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_spatial_hit();
        test_conflict();
        test_stats();
        test_flush();
        test_reset_mid_miss();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
